// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_ctrl
// Purpose  : SPI master with programmable SCLK divider, CPOL/CPHA modes,
//            selectable bit order and one-hot active-low chip selects.
// Revision : 1.0  initial release
// ============================================================================
module spi_master_ctrl #(
   parameter  int DATA_W = 8,
   parameter  int NUM_CS = 4,
   parameter  int DIV_W  = 8,
   localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [DATA_W-1:0] tx_data,
   input  logic [CS_W-1:0]   cs_idx,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              lsb_first,
   input  logic [DIV_W-1:0]  clk_div,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rx_data,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic [NUM_CS-1:0] cs_n
);

   localparam int EDGE_W = $clog2(2 * DATA_W);
   localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_XFER  = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [EDGE_W-1:0] edge_q, edge_d;
   logic              cpha_q, cpha_d;
   logic              lsb_q, lsb_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
   logic [DATA_W-1:0] rx_q, rx_d;
   logic [NUM_CS-1:0] cs_n_q, cs_n_d;

   logic [NUM_CS-1:0] w_cs_dec;
   logic              w_cnt_zero;
   logic              w_bit;
   logic [DATA_W-1:0] w_tx_next;
   logic [DATA_W-1:0] w_rx_next;

   // Out-of-range indices match no line, leaving every select deasserted.
   always_comb begin
      w_cs_dec = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if (cs_idx == CS_W'(i)) w_cs_dec[i] = 1'b0;
      end
   end

   assign w_cnt_zero = (cnt_q == '0);
   assign w_bit      = lsb_q ? tx_q[0] : tx_q[DATA_W-1];
   assign w_tx_next  = lsb_q ? (tx_q >> 1) : (tx_q << 1);
   assign w_rx_next  = lsb_q ? {miso, rx_sh_q[DATA_W-1:1]}
                             : {rx_sh_q[DATA_W-2:0], miso};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      edge_d  = edge_q;
      cpha_d  = cpha_q;
      lsb_d   = lsb_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      done_d  = 1'b0;
      tx_d    = tx_q;
      rx_sh_d = rx_sh_q;
      rx_d    = rx_q;
      cs_n_d  = cs_n_q;

      case (state_q)
         ST_IDLE: begin
            sclk_d = cpol;
            if (start) begin
               state_d = ST_SETUP;
               cnt_d   = clk_div;
               div_d   = clk_div;
               cpha_d  = cpha;
               lsb_d   = lsb_first;
               cs_n_d  = w_cs_dec;
               rx_sh_d = '0;
               edge_d  = '0;
               tx_d    = tx_data;
               // Mode with cpha=0 must present the first bit before edge 1.
               if (!cpha) begin
                  mosi_d = lsb_first ? tx_data[0] : tx_data[DATA_W-1];
                  tx_d   = lsb_first ? (tx_data >> 1) : (tx_data << 1);
               end
            end
         end

         ST_SETUP: begin
            if (w_cnt_zero) begin
               state_d = ST_XFER;
               cnt_d   = div_q;
               edge_d  = '0;
               sclk_d  = ~sclk_q;
               if (cpha_q) begin
                  mosi_d = w_bit;
                  tx_d   = w_tx_next;
               end else begin
                  rx_sh_d = w_rx_next;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         ST_XFER: begin
            if (w_cnt_zero) begin
               cnt_d = div_q;
               if (edge_q == LAST_EDGE) begin
                  state_d = ST_HOLD;
               end else begin
                  edge_d = edge_q + 1'b1;
                  sclk_d = ~sclk_q;
                  // edge_q odd here means the upcoming edge is a leading one.
                  if (edge_q[0] != cpha_q) begin
                     rx_sh_d = w_rx_next;
                  end else if (cpha_q || (edge_d != LAST_EDGE)) begin
                     mosi_d = w_bit;
                     tx_d   = w_tx_next;
                  end
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         ST_HOLD: begin
            if (w_cnt_zero) begin
               state_d = ST_IDLE;
               cs_n_d  = '1;
               rx_d    = rx_sh_q;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         div_q   <= '0;
         edge_q  <= '0;
         cpha_q  <= 1'b0;
         lsb_q   <= 1'b0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         done_q  <= 1'b0;
         tx_q    <= '0;
         rx_sh_q <= '0;
         rx_q    <= '0;
         cs_n_q  <= '1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         edge_q  <= edge_d;
         cpha_q  <= cpha_d;
         lsb_q   <= lsb_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         done_q  <= done_d;
         tx_q    <= tx_d;
         rx_sh_q <= rx_sh_d;
         rx_q    <= rx_d;
         cs_n_q  <= cs_n_d;
      end
   end

   assign busy    = (state_q != ST_IDLE);
   assign done    = done_q;
   assign rx_data = rx_q;
   assign sclk    = sclk_q;
   assign mosi    = mosi_q;
   assign cs_n    = cs_n_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_ctrl
// Purpose  : Scoreboard bench for spi_master_ctrl (loopback and mode-3 slave).
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_master_ctrl;

   typedef struct {
      logic [7:0] rx;
      logic [7:0] stream;
      int         len;
      logic [3:0] cs;
   } exp_t;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic [7:0] tx_data;
   logic [1:0] cs_idx;
   logic [2:0] cs_idx2;
   logic       cpol, cpha, lsb_first;
   logic [7:0] clk_div;
   logic       busy, done, sclk, mosi, miso;
   logic [7:0] rx_data;
   logic [3:0] cs_n;
   logic       busy2, done2, sclk2, mosi2;
   logic [7:0] rx_data2;
   logic [4:0] cs_n2;

   logic       use_slave;
   logic [7:0] slv_word = 8'h3C;
   logic [3:0] slv_cnt;
   logic [7:0] slv_sh;
   logic       slv_bit;
   logic [7:0] slv_rx;

   int         n_vec = 0;
   int         n_err = 0;
   exp_t       sb[$];

   logic       prev_done, prev_sclk;
   int         len, nbits, edges, done_cnt;
   logic [7:0] stream;
   int         edges2, edges2_last, done2_cnt;
   logic       prev_sclk2, cs2bad, cs2bad_last;

   spi_master_ctrl #(.DATA_W(8), .NUM_CS(4), .DIV_W(8)) u_dut (
      .clk(clk), .reset_n(reset_n), .start(start), .tx_data(tx_data),
      .cs_idx(cs_idx), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
      .clk_div(clk_div), .busy(busy), .done(done), .rx_data(rx_data),
      .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
   );

   // Second instance with a non-power-of-two select count for out-of-range indices.
   spi_master_ctrl #(.DATA_W(8), .NUM_CS(5), .DIV_W(8)) u_dut5 (
      .clk(clk), .reset_n(reset_n), .start(start), .tx_data(tx_data),
      .cs_idx(cs_idx2), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
      .clk_div(clk_div), .busy(busy2), .done(done2), .rx_data(rx_data2),
      .sclk(sclk2), .mosi(mosi2), .miso(mosi2), .cs_n(cs_n2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Mode-3 slave on cs_n[0]: shifts out on falling SCLK, captures on rising.
   always @(negedge sclk or posedge cs_n[0]) begin
      if (cs_n[0]) slv_cnt <= 4'd0;
      else         slv_cnt <= slv_cnt + 4'd1;
   end
   assign slv_sh  = slv_word << (slv_cnt - 4'd1);
   assign slv_bit = (slv_cnt == 4'd0) ? 1'b0 : slv_sh[7];
   always @(posedge sclk) begin
      if (!cs_n[0]) slv_rx <= {slv_rx[6:0], mosi};
   end
   assign miso = use_slave ? slv_bit : mosi;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] bitrev(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

   task automatic mon_step();
      exp_t e;
      if (!reset_n) begin
         sb.delete();
         len = 0; nbits = 0; stream = 8'h00; edges = 0;
         edges2 = 0; cs2bad = 1'b0;
      end else begin
         if (done) begin
            chk("done_width", {31'd0, prev_done}, 32'd0);
            done_cnt++;
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("rx_data", {24'd0, rx_data}, {24'd0, e.rx});
               chk("busy_len", len, e.len);
               chk("mosi_stream", {24'd0, stream}, {24'd0, e.stream});
               chk("mosi_bits", nbits, 8);
            end
         end
         if (busy) begin
            len++;
            if (sb.size() > 0) chk("cs_n_during", {28'd0, cs_n}, {28'd0, sb[0].cs});
            if (sclk !== prev_sclk) begin
               edges++;
               if (sclk ^ cpol ^ cpha) begin
                  stream = {stream[6:0], mosi};
                  nbits++;
               end
            end
         end else begin
            len = 0; nbits = 0; stream = 8'h00; edges = 0;
         end
         if (done2) begin
            edges2_last = edges2;
            cs2bad_last = cs2bad;
            done2_cnt++;
         end
         if (busy2) begin
            if (sclk2 !== prev_sclk2) edges2++;
            if (cs_n2 !== 5'b11111) cs2bad = 1'b1;
         end else begin
            edges2 = 0; cs2bad = 1'b0;
         end
      end
      prev_done  = done;
      prev_sclk  = sclk;
      prev_sclk2 = sclk2;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic config_set(input logic [1:0] cs, input logic pol, input logic pha,
                             input logic lsb, input logic [7:0] div);
      cs_idx = cs; cpol = pol; cpha = pha; lsb_first = lsb; clk_div = div;
      step();
      step();
   endtask

   // Pulses start with the current configuration; queues the expectation if accepted.
   task automatic launch(input logic [7:0] tx, input logic [7:0] exp_rx);
      exp_t e;
      tx_data = tx;
      start   = 1'b1;
      if (!busy) begin
         e.rx     = exp_rx;
         e.stream = lsb_first ? bitrev(tx) : tx;
         e.len    = 18 * (int'(clk_div) + 1);
         e.cs     = ~(4'b0001 << cs_idx);
         sb.push_back(e);
      end
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         step();
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      int saved;
      int saved2;
      reset_n = 1'b0; start = 1'b0; tx_data = 8'h00; cs_idx = 2'd0; cs_idx2 = 3'd0;
      cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; clk_div = 8'd1; use_slave = 1'b0;
      prev_done = 1'b0; prev_sclk = 1'b0; prev_sclk2 = 1'b0;
      len = 0; nbits = 0; edges = 0; done_cnt = 0; stream = 8'h00;
      edges2 = 0; edges2_last = 0; done2_cnt = 0; cs2bad = 1'b0; cs2bad_last = 1'b0;
      fork
         forever begin
            @(negedge clk);
            mon_step();
         end
      join_none

      repeat (3) @(posedge clk);
      #2;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_rx", {24'd0, rx_data}, 32'd0);
      chk("rst_sclk", {31'd0, sclk}, 32'd0);
      chk("rst_mosi", {31'd0, mosi}, 32'd0);
      chk("rst_cs_n", {28'd0, cs_n}, 32'hF);
      reset_n = 1'b1;
      step();

      // Mode 0, H=2, loopback, select 2
      config_set(2'd2, 1'b0, 1'b0, 1'b0, 8'd1);
      launch(8'hA5, 8'hA5);
      wait_done("t1");
      chk("t1_cs_release", {28'd0, cs_n}, 32'hF);
      chk("t1_busy_low", {31'd0, busy}, 32'd0);

      // Mode 3 against the slave model
      config_set(2'd0, 1'b1, 1'b1, 1'b0, 8'd1);
      chk("t2_sclk_idle_hi", {31'd0, sclk}, 32'd1);
      use_slave = 1'b1;
      launch(8'hF0, 8'h3C);
      wait_done("t2");
      use_slave = 1'b0;
      chk("t2_slave_rx", {24'd0, slv_rx}, 32'hF0);

      // Mode 1, LSB first
      config_set(2'd1, 1'b0, 1'b1, 1'b1, 8'd1);
      launch(8'h01, 8'h01);
      wait_done("t3");

      // H=1, back-to-back with restart in the done cycle
      config_set(2'd3, 1'b0, 1'b0, 1'b0, 8'd0);
      launch(8'h5A, 8'h5A);
      wait_done("t4a");
      chk("t4_gap_busy_low", {31'd0, busy}, 32'd0);
      launch(8'hC3, 8'hC3);
      chk("t4_b2b_accept", {31'd0, busy}, 32'd1);
      wait_done("t4b");

      // Start while busy is ignored
      config_set(2'd1, 1'b0, 1'b0, 1'b0, 8'd1);
      launch(8'h96, 8'h96);
      repeat (10) step();
      tx_data = 8'h11; cs_idx = 2'd3; start = 1'b1;
      step();
      start = 1'b0;
      wait_done("t5");

      // Asynchronous reset after the fifth SCLK edge
      config_set(2'd0, 1'b0, 1'b0, 1'b0, 8'd1);
      launch(8'h77, 8'h77);
      saved = done_cnt;
      begin
         bit hit = 1'b0;
         for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #7;
            if (edges >= 5) begin
               hit = 1'b1;
               break;
            end
         end
         if (!hit) chk("t5_edge5_timeout", 32'd0, 32'd1);
      end
      chk("t5_pre_sclk", {31'd0, sclk}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("t5_rst_sclk", {31'd0, sclk}, 32'd0);
      chk("t5_rst_cs_n", {28'd0, cs_n}, 32'hF);
      chk("t5_rst_busy", {31'd0, busy}, 32'd0);
      chk("t5_rst_done", {31'd0, done}, 32'd0);
      repeat (3) @(posedge clk);
      #2;
      reset_n = 1'b1;
      repeat (10) step();
      chk("t5_no_done", done_cnt, saved);
      chk("t5_rx_cleared", {24'd0, rx_data}, 32'd0);

      // Out-of-range select on the five-line instance
      cs_idx2 = 3'd5;
      config_set(2'd1, 1'b0, 1'b0, 1'b0, 8'd1);
      saved2 = done2_cnt;
      launch(8'h3E, 8'h3E);
      wait_done("t6");
      @(negedge clk);
      #1;
      chk("t6_done2_seen", done2_cnt, saved2 + 1);
      chk("t6_edges2", edges2_last, 16);
      chk("t6_cs2_all_high", {31'd0, cs2bad_last}, 32'd0);
      chk("t6_rx2", {24'd0, rx_data2}, 32'h3E);
      chk("t6_sb_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
